// File: rtl/custom_axi_ip_regs.sv
// AXI4-Lite register front-end for the custom_axi_ip core: CTRL/DIN/DOUT/STATUS.
// Optional IRQ output and CTRL.IRQ_EN bit enabled by defining CUSTOM_AXI_IP_REGS_IRQ_EN.
module custom_axi_ip_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr_i,
  input  logic                    s_awvalid_i,
  output logic                    s_awready_o,
  input  logic [DATA_WIDTH-1:0]   s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb_i,
  input  logic                    s_wvalid_i,
  output logic                    s_wready_o,
  output logic [1:0]              s_bresp_o,
  output logic                    s_bvalid_o,
  input  logic                    s_bready_i,
  input  logic [ADDR_WIDTH-1:0]   s_araddr_i,
  input  logic                    s_arvalid_i,
  output logic                    s_arready_o,
  output logic [DATA_WIDTH-1:0]   s_rdata_o,
  output logic [1:0]              s_rresp_o,
  output logic                    s_rvalid_o,
  input  logic                    s_rready_i,
  output logic [15:0]             core_din_o,
  output logic                    core_enable_o,
  input  logic [15:0]             core_dout_i,
  input  logic [1:0]              core_enable_out_i,
  input  logic [1:0]              core_status_i
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
  ,
  output logic                    irq_o
`endif
);

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t               wstate;
  rstate_t               rstate;
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [15:0]           wdata_q;
  logic [1:0]            wstrb_q;
  logic [15:0]           din_q, dout_q;
  logic                  done_q, ovr_q;
  logic                  irq_en_q;

  logic                  wr_commit, wr_oor;
  logic                  wr_ctrl, wr_din, wr_stat;
  logic                  rd_oor;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  cap;
  logic                  unused_bits;

  assign wr_commit = (wstate == W_IDLE) && aw_held && w_held;
  assign wr_oor    = (awaddr_q >> 4) != '0;
  assign wr_ctrl   = wr_commit && !wr_oor && (awaddr_q[3:2] == 2'd0);
  assign wr_din    = wr_commit && !wr_oor && (awaddr_q[3:2] == 2'd1);
  assign wr_stat   = wr_commit && !wr_oor && (awaddr_q[3:2] == 2'd3);
  assign rd_oor    = (s_araddr_i >> 4) != '0;
  assign cap       = core_enable_out_i[0];
  assign core_din_o = din_q;

  assign unused_bits = ^{s_wdata_i[DATA_WIDTH-1:16], s_wstrb_i[DATA_WIDTH/8-1:2],
                         awaddr_q[1:0], s_araddr_i[1:0], core_enable_out_i[1]};

  // AW and W are buffered independently; the commit happens once both are held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wstate      <= W_IDLE;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      s_awready_o <= 1'b0;
      s_wready_o  <= 1'b0;
      s_bvalid_o  <= 1'b0;
      s_bresp_o   <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (wr_commit) begin
            wstate      <= W_RESP;
            s_bvalid_o  <= 1'b1;
            s_bresp_o   <= wr_oor ? 2'b10 : 2'b00;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            s_awready_o <= 1'b0;
            s_wready_o  <= 1'b0;
          end else begin
            if (s_awvalid_i && s_awready_o) begin
              awaddr_q <= s_awaddr_i;
              aw_held  <= 1'b1;
            end
            if (s_wvalid_i && s_wready_o) begin
              wdata_q <= s_wdata_i[15:0];
              wstrb_q <= s_wstrb_i[1:0];
              w_held  <= 1'b1;
            end
            s_awready_o <= !(aw_held || (s_awvalid_i && s_awready_o));
            s_wready_o  <= !(w_held || (s_wvalid_i && s_wready_o));
          end
        end
        W_RESP: begin
          if (s_bready_i) begin
            wstate      <= W_IDLE;
            s_bvalid_o  <= 1'b0;
            s_awready_o <= 1'b1;
            s_wready_o  <= 1'b1;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (!rd_oor) begin
      case (s_araddr_i[3:2])
        2'd0: begin
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
          rd_data[1] = irq_en_q;
`endif
        end
        2'd1: rd_data[15:0] = din_q;
        2'd2: rd_data[15:0] = dout_q;
        default: rd_data[3:0] = {ovr_q, done_q, core_status_i};
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rstate      <= R_IDLE;
      s_arready_o <= 1'b0;
      s_rvalid_o  <= 1'b0;
      s_rdata_o   <= '0;
      s_rresp_o   <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (s_arvalid_i && s_arready_o) begin
            rstate      <= R_DATA;
            s_rdata_o   <= rd_data;
            s_rresp_o   <= rd_oor ? 2'b10 : 2'b00;
            s_rvalid_o  <= 1'b1;
            s_arready_o <= 1'b0;
          end else begin
            s_arready_o <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_rready_i) begin
            rstate      <= R_IDLE;
            s_rvalid_o  <= 1'b0;
            s_arready_o <= 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Capture sets DONE/OVERRUN after the W1C mask, so a coincident set wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      din_q         <= '0;
      dout_q        <= '0;
      done_q        <= 1'b0;
      ovr_q         <= 1'b0;
      core_enable_o <= 1'b0;
      irq_en_q      <= 1'b0;
    end else begin
      core_enable_o <= wr_ctrl && wstrb_q[0] && wdata_q[0];
      if (wr_din && wstrb_q[0]) din_q[7:0]  <= wdata_q[7:0];
      if (wr_din && wstrb_q[1]) din_q[15:8] <= wdata_q[15:8];
      if (cap) dout_q <= core_dout_i;
      done_q <= cap | (done_q & !(wr_stat && wstrb_q[0] && wdata_q[2]));
      ovr_q  <= (cap & done_q) | (ovr_q & !(wr_stat && wstrb_q[0] && wdata_q[3]));
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
      if (wr_ctrl && wstrb_q[0]) irq_en_q <= wdata_q[1];
`endif
    end
  end

`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_o <= 1'b0;
    else       irq_o <= irq_en_q & done_q;
  end
`endif

endmodule

// File: doc/custom_axi_ip_regs.md
Name: custom_axi_ip_regs

Overview:
AXI4-Lite slave register front-end that sits directly upstream of the custom_axi_ip core.
- Software-written registers drive the core's din/enable_in.
- The core's dout/enable_out/status_out are captured into readable registers.
- Provides sticky completion and overrun flags so firmware can poll for results.

Parameters:
DATA_WIDTH, 32, AXI-Lite data width; only 32 supported
ADDR_WIDTH, 4, AXI-Lite byte address width; decode uses addr[3:2]

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  asynchronous, active-high reset
s_awaddr_i  in  ADDR_WIDTH  write address
s_awvalid_i  in  1  write address valid
s_awready_o  out  1  write address ready
s_wdata_i  in  DATA_WIDTH  write data
s_wstrb_i  in  DATA_WIDTH/8  byte strobes; per-byte write enable
s_wvalid_i  in  1  write data valid
s_wready_o  out  1  write data ready
s_bresp_o  out  2  write response
s_bvalid_o  out  1  write response valid
s_bready_i  in  1  write response ready
s_araddr_i  in  ADDR_WIDTH  read address
s_arvalid_i  in  1  read address valid
s_arready_o  out  1  read address ready
s_rdata_o  out  DATA_WIDTH  read data
s_rresp_o  out  2  read response
s_rvalid_o  out  1  read data valid
s_rready_i  in  1  read data ready
core_din_o  out  16  to core din; equals DIN[15:0]
core_enable_o  out  1  to core enable_in; single-cycle start pulse
core_dout_i  in  16  from core dout
core_enable_out_i  in  2  from core enable_out; bit0 = result valid
core_status_i  in  2  from core status_out

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous, active-high.
- Reset values: all ready/valid outputs 0, s_bresp_o/s_rresp_o 0, s_rdata_o 0, core_din_o 0, core_enable_o 0, all registers 0.
- Register map:
  - 0x0 CTRL: bit0 START, write-1 pulses; reads 0.
  - 0x4 DIN: [15:0] RW; upper bits read 0.
  - 0x8 DOUT: [15:0] RO.
  - 0xC STATUS:
    - [1:0] live core_status_i.
    - bit2 DONE, sticky, W1C.
    - bit3 OVERRUN, sticky, W1C.
- Write channel, states W_IDLE, W_RESP:
  - In W_IDLE, AW and W are accepted independently; awready=1 while no address is buffered, wready=1 while no data is buffered.
  - When both address and data are held, the register update happens that cycle and the FSM moves to W_RESP with bvalid=1.
  - bvalid holds until bready=1, then returns to W_IDLE. No new AW/W is accepted in W_RESP.
- Read channel, states R_IDLE, R_DATA:
  - arready=1 only in R_IDLE.
  - On AR handshake, rdata/rresp are registered and the FSM moves to R_DATA with rvalid=1 the next cycle.
  - rdata is stable until rready=1, then returns to R_IDLE. Read latency is 1 cycle after AR handshake.
- Decode: addresses outside 0x0–0xC (ADDR_WIDTH>4 upper bits nonzero) give resp SLVERR (2'b10). Writes to them have no effect; reads of them return 0. Writes to DOUT are ignored, resp OKAY.
- START: a committed CTRL write with wstrb[0]=1 and wdata[0]=1 drives core_enable_o=1 for exactly one cycle, starting the cycle after commit.
- Capture: when core_enable_out_i[0]=1, DOUT<=core_dout_i and DONE<=1.
  - If DONE was already 1 at capture, OVERRUN<=1 as well.
- Simultaneous W1C of DONE/OVERRUN and a capture in the same cycle: set wins.
- Reset asserted mid-transaction: all FSMs return to idle immediately, buffered AW/W are discarded, valids drop asynchronously.

Optional Feature:
Macro CUSTOM_AXI_IP_REGS_IRQ_EN.
- Defined:
  - Adds port irq_o out 1, reset 0.
  - CTRL bit1 IRQ_EN is RW.
  - irq_o is registered, = IRQ_EN & DONE; it deasserts the cycle after DONE is cleared.
- Undefined: no irq_o port; CTRL bit1 reads 0 and writes to it are ignored.

Test Plan:
- Reset, then read 0x0/0x4/0x8/0xC -> all rdata 0x0, rresp OKAY, rvalid one cycle after AR handshake.
- Write 0x4=0x0000ABCD, then read 0x4 -> core_din_o=0xABCD, rdata=0x0000ABCD; a write with wstrb=4'b0001 and data 0x12 -> rdata=0x0000AB12.
- Write 0x0=0x1 with AW two cycles before W -> core_enable_o high exactly 1 cycle after commit; bvalid held 3 cycles under bready=0 with no second pulse.
- Drive core_dout_i=0x1235, core_enable_out_i=01 for one cycle -> read 0x8=0x1235, 0xC bit2=1. Repeat pulse -> bit3=1. Write 0xC=0xC while a pulse is applied the same cycle -> bits2/3 remain 1.
- Read 0x10 with ADDR_WIDTH=5 -> rdata 0, rresp 2'b10. Write 0x8 -> DOUT unchanged, bresp OKAY.
- Assert rst_i while bvalid=1 and rvalid=1 -> both drop without waiting for a clock edge; DIN=0 and DONE=0 after release.
